scroll_pixel_fetch: RTL and testbench
=====================================

Name: scroll_pixel_fetch

Overview:
- Pixel-fetch stage directly upstream of the 5-bit palette colour mapper. Converts the VGA raster position (DrawX/DrawY) into frame-buffer reads from a horizontally scrolling half-resolution world map.
- Returns the 5-bit palette index as memMappedValue, cycle-aligned with the current DrawX.
- Accumulates scroll requests and commits them once per frame at the start of vertical blank, so the picture never tears mid-frame.

Parameters:
- MEM_LAT, 2, frame-buffer read latency in Clk cycles from mem_addr/mem_rd to valid mem_rdata.
- WORLD_W, 1024, world width in frame-buffer pixels; must be a power of 2 and at most 1024.
- ADDR_W, 18, frame-buffer address width; WORLD_W*240 must fit in ADDR_W bits.

Ports:
- Clk  in  1  pixel clock; DrawX advances by 1 per Clk.
- Reset  in  1  asynchronous, active-low reset.
- DrawX  in  10  raster column, 0..799; 0..639 is active.
- DrawY  in  10  raster line, 0..524; 0..479 is active.
- scroll_req  in  1  one-cycle request to scroll right by scroll_amt.
- scroll_amt  in  4  scroll step in frame-buffer pixels.
- mem_addr  out  ADDR_W  frame-buffer read address, registered.
- mem_rd  out  1  read strobe, registered.
- mem_rdata  in  5  frame-buffer data, valid MEM_LAT cycles after mem_rd.
- memMappedValue  out  5  palette index for the current DrawX/DrawY, registered.
- scroll_x  out  10  committed scroll offset, modulo WORLD_W.
- frame_tick  out  1  one-cycle pulse on the commit cycle.

Behaviour:
- Reset values: all outputs 0; internal pending accumulator 0; FSM in VBL.
- Lookahead L = MEM_LAT+2.
  - In the cycle where DrawX=d, the target is t=(d+L) mod 800.
  - Target line ty = DrawY when d+L<800. Otherwise ty = (DrawY+1) mod 525.
  - At the next Clk edge, mem_addr and mem_rd are registered.
  - mem_rdata is registered into memMappedValue MEM_LAT+1 cycles after the address edge.
  - Net effect: memMappedValue always corresponds to the present DrawX/DrawY.
- Address: if t<640 and ty<480, then mem_rd=1 and mem_addr = ((scroll_x + t[9:1]) mod WORLD_W) + ty[9:1]*WORLD_W. This gives 2x2 pixel doubling.
- Blanked targets: mem_rd=0 and mem_addr holds its last value. A valid bit travels in a shift register of length MEM_LAT+1 alongside the read. When the valid bit is 0, memMappedValue=5'h00 and mem_rdata is ignored.
- FSM states:
  - RUN: fetching.
  - COMMIT: single cycle.
  - VBL: no fetches issued.
- FSM transitions:
  - RUN -> COMMIT when DrawY==480 && DrawX==0.
  - COMMIT -> VBL unconditionally.
  - VBL -> RUN when the lookahead target first enters line 0, i.e. DrawY==524 && DrawX==800-L.
  - Any state -> VBL on reset.
  - Fetch address generation is gated to RUN only.
- COMMIT actions:
  - scroll_x <= (scroll_x + pending) mod WORLD_W.
  - pending <= 0.
  - frame_tick=1 for this cycle only.
  - The new scroll_x is first used by addresses issued after COMMIT, i.e. from line 0 of the next frame.
- Pending accumulator: 8 bits, unsigned, saturating at 255. Each scroll_req adds scroll_amt. scroll_amt=0 is legal (no change).
- Simultaneous scroll_req and COMMIT: the request is not included in the current commit; pending <= scroll_amt after the commit.
- Wrap-around: the scroll_x + t[9:1] sum is computed at 11 bits, then masked to log2(WORLD_W) bits.
- Reset asserted mid-line: everything clears immediately, including the valid shift register. After release, memMappedValue stays 0 until the first RUN fetch completes the pipeline.
- DrawX/DrawY out of range (≥800 or ≥525) are treated as blanking: no read, output 0.

Test Plan:
- Reset release, raster runs from DrawY=524, DrawX=790 with MEM_LAT=2 and the memory model returning addr[4:0] -> the first mem_rd=1 occurs with mem_addr=0 at the edge after DrawX=796. At DrawX=0, DrawY=0: memMappedValue=0; at DrawX=2: memMappedValue=1; scroll_x=0.
- Pipeline alignment: memory returns (addr mod 23). At DrawY=2, DrawX=100, scroll_x=0 -> address issued 1*1024+50, and memMappedValue equals (1074 mod 23)=16 while DrawX=100.
- Blanking: for DrawX 640..799 and DrawY 480..524, memMappedValue=0 and mem_rd=0 throughout; also holds when the memory model drives 5'h1F.
- Scroll commit: scroll_req pulses with amt 5, 7 and 15 mid-frame -> scroll_x unchanged until DrawY=480, DrawX=0. Then frame_tick=1 for one cycle and scroll_x=27. Next frame, DrawY=0, DrawX=0 reads address 27.
- Saturation and coincidence: twenty pulses of amt 15 -> committed step is 255, not 300. A pulse of amt 9 on the COMMIT cycle -> next frame commits +9.
- World wrap: scroll_x=1000, DrawX=100, DrawY=0 -> mem_addr=(1000+50) mod 1024 = 26. Reset asserted at DrawX=300 -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/scroll_pixel_fetch.sv
// scroll_pixel_fetch: turns the raster position into look-ahead frame-buffer reads of a
// scrolling half-resolution world map, committing scroll changes once per frame.
module scroll_pixel_fetch #(
  parameter int MEM_LAT = 2,
  parameter int WORLD_W = 1024,
  parameter int ADDR_W  = 18
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              scroll_req,
  input  logic [3:0]        scroll_amt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [4:0]        mem_rdata,
  output logic [4:0]        memMappedValue,
  output logic [9:0]        scroll_x,
  output logic              frame_tick
);
  localparam logic [10:0] LOOK  = 11'(MEM_LAT + 2);
  localparam logic [10:0] XMASK = 11'(WORLD_W - 1);
  localparam int          XW    = $clog2(WORLD_W);
  typedef enum logic [1:0] {VBL, RUN, COMMIT} state_t;
  state_t              state;
  logic [7:0]          pending;
  logic [MEM_LAT:0]    vld;
  logic [10:0]         sum;
  logic [10:0]         xs;
  logic [9:0]          t;
  logic [9:0]          ty;
  logic                wrap;
  logic                go;
  logic                fetch;
  logic [8:0]          acc;
  logic [7:0]          pend_add;
  logic [ADDR_W-1:0]   addr;
  assign mem_rd = vld[0];
  always_comb begin
    sum      = {1'b0, DrawX} + LOOK;
    wrap     = sum >= 11'd800;
    t        = wrap ? 10'(sum - 11'd800) : sum[9:0];
    ty       = wrap ? (DrawY == 10'd524 ? 10'd0 : DrawY + 10'd1) : DrawY;
    go       = state == VBL && DrawY == 10'd524 && DrawX == 10'(11'd800 - LOOK);
    fetch    = (state == RUN || go) && DrawX < 10'd800 && DrawY < 10'd525 && t < 10'd640 && ty < 10'd480;
    xs       = ({1'b0, scroll_x} + 11'(t >> 1)) & XMASK;
    addr     = ADDR_W'(xs) + (ADDR_W'(ty >> 1) << XW);
    acc      = {1'b0, pending} + {5'b0, scroll_amt};
    pend_add = !scroll_req ? pending : (acc[8] ? 8'hFF : acc[7:0]);
  end
  // vld[0] doubles as the read strobe; vld[MEM_LAT] lines up with mem_rdata
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state          <= VBL;
      pending        <= 8'd0;
      scroll_x       <= 10'd0;
      frame_tick     <= 1'b0;
      mem_addr       <= '0;
      vld            <= '0;
      memMappedValue <= 5'h00;
    end else begin
      vld            <= {vld[MEM_LAT-1:0], fetch};
      mem_addr       <= fetch ? addr : mem_addr;
      memMappedValue <= vld[MEM_LAT] ? mem_rdata : 5'h00;
      frame_tick     <= 1'b0;
      pending        <= pend_add;
      case (state)
        VBL:    state <= go ? RUN : VBL;
        RUN: begin
          if (DrawY == 10'd480 && DrawX == 10'd0) begin
            state      <= COMMIT;
            scroll_x   <= 10'(({1'b0, scroll_x} + {3'b0, pending}) & XMASK);
            pending    <= scroll_req ? {4'b0, scroll_amt} : 8'd0;
            frame_tick <= 1'b1;
          end
        end
        default: state <= VBL;
      endcase
    end
  end
endmodule

// File: tb/tb_scroll_pixel_fetch.sv
// tb_scroll_pixel_fetch: scoreboard bench driving a sparse raster walk against a
// position-level reference model of the fetch pipeline and scroll commits.
module tb_scroll_pixel_fetch;
  localparam int L = 4;
  localparam int W = 1024;
  logic        Clk;
  logic        Reset;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        scroll_req;
  logic [3:0]  scroll_amt;
  logic [17:0] mem_addr;
  logic        mem_rd;
  logic [4:0]  mem_rdata;
  logic [4:0]  memMappedValue;
  logic [9:0]  scroll_x;
  logic        frame_tick;

  scroll_pixel_fetch dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .scroll_req(scroll_req), .scroll_amt(scroll_amt),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .memMappedValue(memMappedValue), .scroll_x(scroll_x), .frame_tick(frame_tick)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {int pix; int rd; int addr; int sx; int tick;} exp_t;
  exp_t sb[$];
  int   pq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   mode = 0;
  int   m_sx, m_pend, m_addr;
  bit   m_rd, m_tick, m_run;

  function automatic int memf(input int md, input int a);
    return md == 0 ? a % 32 : md == 1 ? a % 23 : 31;
  endfunction

  // frame buffer with MEM_LAT=2 cycles from address to data
  logic [4:0] mp0, mp1;
  always @(posedge Clk) begin
    mp0 <= 5'(memf(mode, int'(mem_addr)));
    mp1 <= mp0;
  end
  assign mem_rdata = mp1;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (DrawX=%0d DrawY=%0d t=%0t)", nm, act, exp_v, DrawX, DrawY, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pixel", int'(memMappedValue), e.pix);
      chk("mem_rd", int'(mem_rd), e.rd);
      chk("mem_addr", int'(mem_addr), e.addr);
      chk("scroll_x", int'(scroll_x), e.sx);
      chk("frame_tick", int'(frame_tick), e.tick);
    end
  end

  task automatic model_reset();
    m_sx = 0; m_pend = 0; m_addr = 0; m_rd = 0; m_tick = 0; m_run = 0;
    pq.delete();
  endtask

  // one raster cycle: the expected outputs for this cycle come from earlier cycles,
  // and the target L positions ahead decides what this cycle fetches
  task automatic drive(input int x, input int y, input bit req = 1'b0, input int amt = 0);
    exp_t e;
    int   tl, tx, tyy;
    bit   go, fetch;
    @(posedge Clk); #1;
    DrawX = 10'(x); DrawY = 10'(y); scroll_req = req; scroll_amt = 4'(amt);
    e.rd = int'(m_rd); e.addr = m_addr; e.sx = m_sx; e.tick = int'(m_tick);
    e.pix = (pq.size() == L) ? pq.pop_front() : 0;
    sb.push_back(e);
    if (!Reset) return;
    go    = !m_run && x == 800 - L && y == 524;
    tl    = (y * 800 + x + L) % (800 * 525);
    tx    = tl % 800;
    tyy   = tl / 800;
    fetch = (m_run || go) && x < 800 && y < 525 && tx < 640 && tyy < 480;
    m_rd  = fetch;
    if (fetch) m_addr = ((m_sx + tx / 2) % W) + (tyy / 2) * W;
    pq.push_back(fetch ? memf(mode, m_addr) : 0);
    m_tick = 0;
    if (go) m_run = 1;
    else if (m_run && x == 0 && y == 480) begin
      m_tick = 1; m_run = 0;
      m_sx   = (m_sx + m_pend) % W;
      m_pend = req ? amt : 0;
    end else if (req) m_pend = (m_pend + amt > 255) ? 255 : m_pend + amt;
  endtask

  task automatic line(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) drive(x, y);
  endtask

  task automatic pulses(input int total);
    int x = 0;
    while (total > 0) begin
      int a = total > 15 ? 15 : total;
      drive(x, 200, 1'b1, a);
      drive(x + 1, 200);
      x += 2;
      total -= a;
    end
  endtask

  task automatic frame_start(input int s);
    line(524, 780, 796);
    line(524, 797, 797);
    chk("first_rd", int'(mem_rd), 1);
    chk("first_addr", int'(mem_addr), s);
    line(524, 798, 799);
    line(0, 0, 0);
    chk("first_pixel", int'(memMappedValue), s % 23);
    line(0, 1, 20);
    line(0, 650, 700);
  endtask

  task automatic frame_end(input int c, input int exp_sx);
    line(479, 790, 799);
    drive(0, 480, c != 0, c);
    line(480, 1, 1);
    chk("commit_tick", int'(frame_tick), 1);
    chk("commit_sx", int'(scroll_x), exp_sx);
    line(480, 2, 20);
  endtask

  initial begin
    Reset = 1'b0; DrawX = 10'd0; DrawY = 10'd0; scroll_req = 1'b0; scroll_amt = 4'd0;
    model_reset();
    for (int x = 785; x <= 789; x++) drive(x, 524);
    Reset = 1'b1;
    // frame A: memory returns addr[4:0]
    line(524, 790, 796);
    line(524, 797, 797);
    chk("a_first_rd", int'(mem_rd), 1);
    chk("a_first_addr", int'(mem_addr), 0);
    line(524, 798, 799);
    line(0, 0, 0);
    chk("a_pix_x0", int'(memMappedValue), 0);
    chk("a_sx", int'(scroll_x), 0);
    line(0, 1, 2);
    chk("a_pix_x2", int'(memMappedValue), 1);
    line(0, 3, 20);
    line(0, 650, 700);
    mode = 1;
    line(2, 0, 100);
    chk("align_pix", int'(memMappedValue), 16);
    line(2, 101, 120);
    line(100, 0, 9);
    drive(10, 100, 1'b1, 5);
    line(100, 11, 19);
    drive(20, 100, 1'b1, 7);
    line(100, 21, 29);
    drive(30, 100, 1'b1, 15);
    line(100, 31, 40);
    chk("sx_held", int'(scroll_x), 0);
    frame_end(0, 27);
    // vertical blank with the memory driving all ones, plus out-of-range positions
    mode = 2;
    line(500, 600, 799);
    drive(900, 600); drive(1023, 1023); drive(810, 100);
    line(523, 790, 799);
    mode = 1;
    // frame B: random traffic, saturation, request coinciding with commit
    frame_start(27);
    for (int s = 0; s < 12; s++) begin
      int y = $urandom_range(3, 470);
      int x0 = $urandom_range(0, 700);
      int x1 = x0 + $urandom_range(10, 90);
      if (x1 > 799) x1 = 799;
      for (int x = x0; x <= x1; x++) drive(x, y, $urandom_range(0, 3) == 0, $urandom_range(0, 15));
    end
    pulses(300);
    drive(850, 100); drive(850, 101); drive(0, 600); drive(1023, 1023);
    line(150, 0, 60);
    frame_end(9, 282);
    frame_start(282);
    frame_end(0, 291);
    frame_start(291); pulses(255); frame_end(0, 546);
    frame_start(546); pulses(255); frame_end(0, 801);
    frame_start(801); pulses(199); frame_end(0, 1000);
    // world wrap
    line(524, 780, 799);
    line(0, 0, 97);
    chk("wrap_rd", int'(mem_rd), 1);
    chk("wrap_addr", int'(mem_addr), 26);
    chk("wrap_sx", int'(scroll_x), 1000);
    line(0, 98, 300);
    // asynchronous reset in the middle of a line
    @(negedge Clk); #2;
    Reset = 1'b0;
    #1;
    chk("rst_pix", int'(memMappedValue), 0);
    chk("rst_rd", int'(mem_rd), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_sx", int'(scroll_x), 0);
    chk("rst_tick", int'(frame_tick), 0);
    model_reset();
    line(0, 301, 320);
    Reset = 1'b1;
    line(0, 321, 400);
    line(524, 790, 799);
    line(0, 0, 10);
    chk("post_rst_sx", int'(scroll_x), 0);
    repeat (2) @(negedge Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
